// File: rtl/multicycle_control_if.sv
// Control/datapath bundle between the multicycle controller and the datapath/memories.
// master = controller view, slave = datapath view.
interface multicycle_control_if;
    logic [5:0] Opcode;
    logic [5:0] Func;
    logic       Zero;
    logic       Instr_Ack;
    logic       Mem_Ack;
    logic [3:0] ALU_op;
    logic       ALU_Bsel;
    logic [1:0] Imm_ext;
    logic       PC_LdEn;
    logic       PC_sel;
    logic       IR_LdEn;
    logic       RF_WrEn;
    logic       RF_Wsel;
    logic       Instr_Req;
    logic       Mem_Req;
    logic       Mem_WE;
    logic       Illegal;
    logic       Bus_Err;

    modport master (
        input  Opcode, Func, Zero, Instr_Ack, Mem_Ack,
        output ALU_op, ALU_Bsel, Imm_ext, PC_LdEn, PC_sel, IR_LdEn,
               RF_WrEn, RF_Wsel, Instr_Req, Mem_Req, Mem_WE, Illegal, Bus_Err
    );

    modport slave (
        output Opcode, Func, Zero, Instr_Ack, Mem_Ack,
        input  ALU_op, ALU_Bsel, Imm_ext, PC_LdEn, PC_sel, IR_LdEn,
               RF_WrEn, RF_Wsel, Instr_Req, Mem_Req, Mem_WE, Illegal, Bus_Err
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: fetch/decode/execute/memory/writeback sequencing
// with req/ack waits guarded by an ack timeout.
module multicycle_control #(
    parameter int ACK_TIMEOUT = 16,
    parameter int TW          = 5
) (
    input  logic                  Clk,
    input  logic                  Reset,
    multicycle_control_if.master  bus
);
    typedef enum logic [3:0] {
        S_INIT, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_ALU,
        S_EXEC_BR, S_ADDR, S_MEM_RD, S_MEM_WR, S_WB_MEM
    } state_t;

    localparam logic [5:0] OP_R    = 6'b100000;
    localparam logic [5:0] OP_ADDI = 6'b110000;
    localparam logic [5:0] OP_ANDI = 6'b110010;
    localparam logic [5:0] OP_ORI  = 6'b110011;
    localparam logic [5:0] OP_B    = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000001;
    localparam logic [5:0] OP_BNE  = 6'b000010;
    localparam logic [5:0] OP_LW   = 6'b001111;
    localparam logic [5:0] OP_SW   = 6'b011111;

    state_t        state, state_next;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit, tmo_clr, hold_ld;
    logic [3:0]    alu_op, alu_q;
    logic          alu_bsel, bsel_q;
    logic [1:0]    imm_ext, imm_q;
    logic          bus_err, req;
    logic          unused_func_hi;

    assign unused_func_hi = ^bus.Func[5:4];

    function automatic logic alu_legal(input logic [3:0] f);
        case (f)
            4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
            4'b1000, 4'b1001, 4'b1010, 4'b1100, 4'b1101: return 1'b1;
            default:                                      return 1'b0;
        endcase
    endfunction

    // Hit on the ACK_TIMEOUT-th consecutive Req cycle; an Ack that cycle still wins.
    assign tmo_hit = (tmo_cnt == TW'(ACK_TIMEOUT - 1));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= S_INIT;
            tmo_cnt <= '0;
            alu_q   <= '0;
            bsel_q  <= 1'b0;
            imm_q   <= '0;
        end else begin
            state <= state_next;
            if (tmo_clr)  tmo_cnt <= '0;
            else if (req) tmo_cnt <= tmo_cnt + 1'b1;
            if (hold_ld) begin
                alu_q  <= alu_op;
                bsel_q <= alu_bsel;
                imm_q  <= imm_ext;
            end
        end
    end

    always_comb begin
        state_next    = state;
        alu_op        = 4'b0000;
        alu_bsel      = 1'b0;
        imm_ext       = 2'b00;
        hold_ld       = 1'b0;
        bus_err       = 1'b0;
        bus.PC_LdEn   = 1'b0;
        bus.PC_sel    = 1'b0;
        bus.IR_LdEn   = 1'b0;
        bus.RF_WrEn   = 1'b0;
        bus.RF_Wsel   = 1'b0;
        bus.Instr_Req = 1'b0;
        bus.Mem_Req   = 1'b0;
        bus.Mem_WE    = 1'b0;
        bus.Illegal   = 1'b0;
        case (state)
            S_INIT: state_next = S_FETCH;
            S_FETCH: begin
                bus.Instr_Req = 1'b1;
                if (bus.Instr_Ack) begin
                    bus.IR_LdEn = 1'b1;
                    bus.PC_LdEn = 1'b1;
                    state_next  = S_DECODE;
                end else if (tmo_hit) begin
                    bus_err = 1'b1;
                end
            end
            S_DECODE: begin
                case (bus.Opcode)
                    OP_R: begin
                        if (alu_legal(bus.Func[3:0])) state_next = S_EXEC_R;
                        else begin
                            bus.Illegal = 1'b1;
                            state_next  = S_FETCH;
                        end
                    end
                    OP_ADDI, OP_ANDI, OP_ORI: state_next = S_EXEC_I;
                    OP_B, OP_BEQ, OP_BNE:     state_next = S_EXEC_BR;
                    OP_LW, OP_SW:             state_next = S_ADDR;
                    default: begin
                        bus.Illegal = 1'b1;
                        state_next  = S_FETCH;
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_op     = bus.Func[3:0];
                hold_ld    = 1'b1;
                state_next = S_WB_ALU;
            end
            S_EXEC_I: begin
                alu_bsel = 1'b1;
                case (bus.Opcode)
                    OP_ANDI: begin alu_op = 4'b0010; imm_ext = 2'b01; end
                    OP_ORI:  begin alu_op = 4'b0011; imm_ext = 2'b01; end
                    default: begin alu_op = 4'b0000; imm_ext = 2'b00; end
                endcase
                hold_ld    = 1'b1;
                state_next = S_WB_ALU;
            end
            S_WB_ALU: begin
                alu_op      = alu_q;
                alu_bsel    = bsel_q;
                imm_ext     = imm_q;
                bus.RF_WrEn = 1'b1;
                state_next  = S_FETCH;
            end
            S_EXEC_BR: begin
                alu_op     = 4'b0001;
                imm_ext    = 2'b10;
                bus.PC_sel = 1'b1;
                case (bus.Opcode)
                    OP_BEQ:  bus.PC_LdEn = bus.Zero;
                    OP_BNE:  bus.PC_LdEn = ~bus.Zero;
                    default: bus.PC_LdEn = 1'b1;
                endcase
                state_next = S_FETCH;
            end
            S_ADDR: begin
                alu_bsel   = 1'b1;
                hold_ld    = 1'b1;
                state_next = (bus.Opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD, S_MEM_WR: begin
                alu_op      = alu_q;
                alu_bsel    = bsel_q;
                imm_ext     = imm_q;
                bus.Mem_Req = 1'b1;
                bus.Mem_WE  = (state == S_MEM_WR);
                if (bus.Mem_Ack) begin
                    state_next = (state == S_MEM_RD) ? S_WB_MEM : S_FETCH;
                end else if (tmo_hit) begin
                    bus_err    = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_WB_MEM: begin
                bus.RF_WrEn = 1'b1;
                bus.RF_Wsel = 1'b1;
                state_next  = S_FETCH;
            end
            default: state_next = S_INIT;
        endcase
    end

    // A timeout in FETCH stays in FETCH, so it must restart the count explicitly.
    assign tmo_clr      = (state_next != state) || bus_err;
    assign req          = bus.Instr_Req | bus.Mem_Req;
    assign bus.ALU_op   = alu_op;
    assign bus.ALU_Bsel = alu_bsel;
    assign bus.Imm_ext  = imm_ext;
    assign bus.Bus_Err  = bus_err;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class, ack waits,
// timeouts, illegal decodes and mid-operation reset against hand-computed outputs.
module tb_multicycle_control;
    logic Clk = 1'b0;
    logic Reset;
    int   n_cmp = 0;
    int   n_err = 0;

    multicycle_control_if bus ();

    multicycle_control #(.ACK_TIMEOUT(4), .TW(3)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    // {ALU_op, Bsel, Imm_ext, PC_LdEn, PC_sel, IR_LdEn, RF_WrEn, RF_Wsel,
    //  Instr_Req, Mem_Req, Mem_WE, Illegal, Bus_Err}
    logic [16:0] outs;
    assign outs = {bus.ALU_op, bus.ALU_Bsel, bus.Imm_ext, bus.PC_LdEn, bus.PC_sel,
                   bus.IR_LdEn, bus.RF_WrEn, bus.RF_Wsel, bus.Instr_Req, bus.Mem_Req,
                   bus.Mem_WE, bus.Illegal, bus.Bus_Err};

    localparam logic [9:0] F_PCLD  = 10'h200;
    localparam logic [9:0] F_PCSEL = 10'h100;
    localparam logic [9:0] F_IRLD  = 10'h080;
    localparam logic [9:0] F_RFWR  = 10'h040;
    localparam logic [9:0] F_RFWS  = 10'h020;
    localparam logic [9:0] F_IREQ  = 10'h010;
    localparam logic [9:0] F_MREQ  = 10'h008;
    localparam logic [9:0] F_MWE   = 10'h004;
    localparam logic [9:0] F_ILL   = 10'h002;
    localparam logic [9:0] F_BERR  = 10'h001;

    function automatic logic [16:0] ev(input logic [3:0] alu, input logic bsel,
                                       input logic [1:0] imm, input logic [9:0] fl);
        return {alu, bsel, imm, fl};
    endfunction

    task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %05h want %05h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic look(input string tag, input logic [16:0] exp);
        #1;
        chk(tag, outs, exp);
    endtask

    // Called in a FETCH cycle: ack this cycle, leaves the bench in DECODE.
    task automatic do_fetch(input string tag, input logic [5:0] op, input logic [5:0] fn);
        bus.Opcode    = op;
        bus.Func      = fn;
        bus.Instr_Ack = 1'b1;
        look(tag, ev(4'h0, 1'b0, 2'b00, F_PCLD | F_IRLD | F_IREQ));
        cyc();
        bus.Instr_Ack = 1'b0;
    endtask

    task automatic do_branch(input string tag, input logic [5:0] op, input logic z,
                             input logic [9:0] fl);
        do_fetch({tag, "_f"}, op, 6'd0);
        look({tag, "_dec"}, '0);
        cyc();
        bus.Zero = z;
        look(tag, ev(4'h1, 1'b0, 2'b10, fl));
        cyc();
        bus.Zero = 1'b0;
    endtask

    task automatic do_itype(input string tag, input logic [5:0] op,
                            input logic [3:0] alu, input logic [1:0] imm);
        do_fetch({tag, "_f"}, op, 6'd0);
        look({tag, "_dec"}, '0);
        cyc();
        look({tag, "_ex"}, ev(alu, 1'b1, imm, 10'h0));
        cyc();
        look({tag, "_wb"}, ev(alu, 1'b1, imm, F_RFWR));
        cyc();
    endtask

    initial begin
        Reset         = 1'b1;
        bus.Opcode    = '0;
        bus.Func      = '0;
        bus.Zero      = 1'b0;
        bus.Instr_Ack = 1'b0;
        bus.Mem_Ack   = 1'b0;
        repeat (2) cyc();
        look("rst", '0);
        Reset = 1'b0;
        look("init", '0);
        cyc();
        look("fetch0", ev(4'h0, 1'b0, 2'b00, F_IREQ));

        // R-type sub: FETCH, DECODE, EXEC_R, WB_ALU
        do_fetch("r_f", 6'b100000, 6'b000001);
        look("r_dec", '0);
        cyc();
        look("r_ex", ev(4'h1, 1'b0, 2'b00, 10'h0));
        cyc();
        look("r_wb", ev(4'h1, 1'b0, 2'b00, F_RFWR));
        cyc();
        look("r_next", ev(4'h0, 1'b0, 2'b00, F_IREQ));

        // R-type rol, upper Func bits ignored
        do_fetch("rol_f", 6'b100000, 6'b111100);
        cyc();
        look("rol_ex", ev(4'hC, 1'b0, 2'b00, 10'h0));
        cyc();
        look("rol_wb", ev(4'hC, 1'b0, 2'b00, F_RFWR));
        cyc();

        do_branch("beq_z1", 6'b000001, 1'b1, F_PCLD | F_PCSEL);
        do_branch("beq_z0", 6'b000001, 1'b0, F_PCSEL);
        do_branch("bne_z1", 6'b000010, 1'b1, F_PCSEL);
        do_branch("bne_z0", 6'b000010, 1'b0, F_PCLD | F_PCSEL);
        do_branch("b_z0",   6'b000000, 1'b0, F_PCLD | F_PCSEL);

        do_itype("andi", 6'b110010, 4'h2, 2'b01);
        do_itype("ori",  6'b110011, 4'h3, 2'b01);

        // lw with Mem_Ack on the 4th request cycle (same cycle as the timeout limit)
        do_fetch("lw_f", 6'b001111, 6'd0);
        look("lw_dec", '0);
        cyc();
        look("lw_addr", ev(4'h0, 1'b1, 2'b00, 10'h0));
        for (int i = 0; i < 3; i++) begin
            cyc();
            look("lw_wait", ev(4'h0, 1'b1, 2'b00, F_MREQ));
        end
        cyc();
        bus.Mem_Ack = 1'b1;
        look("lw_ack", ev(4'h0, 1'b1, 2'b00, F_MREQ));
        cyc();
        bus.Mem_Ack = 1'b0;
        look("lw_wb", ev(4'h0, 1'b0, 2'b00, F_RFWR | F_RFWS));
        cyc();
        look("lw_next", ev(4'h0, 1'b0, 2'b00, F_IREQ));

        // lw with no Mem_Ack: Bus_Err on 4th cycle, back to FETCH
        do_fetch("lwto_f", 6'b001111, 6'd0);
        cyc();
        for (int i = 0; i < 3; i++) begin
            cyc();
            look("lwto_wait", ev(4'h0, 1'b1, 2'b00, F_MREQ));
        end
        cyc();
        look("lwto_err", ev(4'h0, 1'b1, 2'b00, F_MREQ | F_BERR));
        cyc();

        // FETCH timeout, then refetch with Ack exactly on the 4th cycle
        for (int i = 0; i < 3; i++) begin
            look("ito_wait", ev(4'h0, 1'b0, 2'b00, F_IREQ));
            cyc();
        end
        look("ito_err", ev(4'h0, 1'b0, 2'b00, F_IREQ | F_BERR));
        cyc();
        for (int i = 0; i < 3; i++) begin
            look("ito_wait2", ev(4'h0, 1'b0, 2'b00, F_IREQ));
            cyc();
        end
        do_fetch("ito_ack", 6'b110000, 6'd0);
        look("addi_dec", '0);
        cyc();
        look("addi_ex", ev(4'h0, 1'b1, 2'b00, 10'h0));
        cyc();
        look("addi_wb", ev(4'h0, 1'b1, 2'b00, F_RFWR));
        cyc();

        // Illegal opcode and illegal R-type function
        do_fetch("ill_op_f", 6'b010101, 6'd0);
        look("ill_op", ev(4'h0, 1'b0, 2'b00, F_ILL));
        cyc();
        look("ill_op_next", ev(4'h0, 1'b0, 2'b00, F_IREQ));
        do_fetch("ill_fn_f", 6'b100000, 6'b000111);
        look("ill_fn", ev(4'h0, 1'b0, 2'b00, F_ILL));
        cyc();
        look("ill_fn_next", ev(4'h0, 1'b0, 2'b00, F_IREQ));

        // sw with immediate ack
        do_fetch("sw_f", 6'b011111, 6'd0);
        cyc();
        look("sw_addr", ev(4'h0, 1'b1, 2'b00, 10'h0));
        cyc();
        bus.Mem_Ack = 1'b1;
        look("sw_ack", ev(4'h0, 1'b1, 2'b00, F_MREQ | F_MWE));
        cyc();
        bus.Mem_Ack = 1'b0;
        look("sw_next", ev(4'h0, 1'b0, 2'b00, F_IREQ));

        // sw interrupted by reset while in MEM_WR
        do_fetch("swr_f", 6'b011111, 6'd0);
        cyc();
        cyc();
        look("swr_memwr", ev(4'h0, 1'b1, 2'b00, F_MREQ | F_MWE));
        Reset = 1'b1;
        look("swr_rst", '0);
        cyc();
        look("swr_rst_hold", '0);
        Reset = 1'b0;
        look("swr_init", '0);
        cyc();
        look("swr_fetch", ev(4'h0, 1'b0, 2'b00, F_IREQ));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
